// File: rtl/lcd_feeder.sv
// Host command FIFO feeding an LCD controller; a load (code 0) streams PIX_NUM image ROM pixels.
// Defining LCD_FEEDER_TIMEOUT_EN adds a 256-cycle busy timeout in WAITLO that sets a sticky err.
module lcd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_NUM    = 108
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic       img_rd,
    output logic [6:0] img_addr,
    input  logic [7:0] img_data,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    output logic       cmd_done,
    output logic       err,
    output logic [2:0] fsm_state
);
    // Host handshake: a command transfers on each rising edge with host_valid && host_ready;
    // host_ready is registered as !full, and a stored entry can only be popped from the next cycle.
    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [6:0]      LAST_PIX  = 7'(PIX_NUM - 1);
    localparam logic [2:0]      CODE_LOAD = 3'd0;
    localparam logic [2:0]      CODE_DROP = 3'd7;

    typedef enum logic [2:0] {IDLE, PRE, ISSUE, STREAM, WAITLO} state_t;
    state_t state, state_n;

    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_n;
    logic             push, pop, empty;
    logic [2:0]       head;

    logic [2:0] cur_code, cur_code_n;
    logic [6:0] pix_cnt, pix_cnt_n;
    logic       img_rd_n, cmd_valid_n, cmd_done_n;
    logic [6:0] img_addr_n;
    logic [2:0] cmd_n;
    logic [7:0] datain_n;

    assign push      = host_valid && host_ready && (host_cmd != CODE_DROP);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign fsm_state = state;

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + (PTR_W + 1)'(1);
        else if (!push && pop)
            count_n = count - (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            host_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_n;
            host_ready <= (count_n != DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

`ifdef LCD_FEEDER_TIMEOUT_EN
    logic [7:0] to_cnt, to_cnt_n;
    logic       err_n;
`endif

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        cur_code_n  = cur_code;
        pix_cnt_n   = pix_cnt;
        img_rd_n    = 1'b0;
        img_addr_n  = '0;
        cmd_n       = '0;
        cmd_valid_n = 1'b0;
        datain_n    = '0;
        cmd_done_n  = 1'b0;
`ifdef LCD_FEEDER_TIMEOUT_EN
        to_cnt_n    = '0;
        err_n       = err;
`endif
        // ROM read walk: once started in PRE it runs unbroken until the last address.
        if (img_rd && img_addr != LAST_PIX) begin
            img_rd_n   = 1'b1;
            img_addr_n = img_addr + 7'd1;
        end
        case (state)
            IDLE: begin
                if (!empty && !busy) begin
                    pop        = 1'b1;
                    cur_code_n = head;
                    if (head == CODE_LOAD) begin
                        state_n    = PRE;
                        img_rd_n   = 1'b1;
                        img_addr_n = '0;
                    end else begin
                        state_n     = ISSUE;
                        cmd_valid_n = 1'b1;
                        cmd_n       = head;
                    end
                end
            end
            PRE: begin
                state_n     = ISSUE;
                cmd_valid_n = 1'b1;
                cmd_n       = cur_code;
            end
            ISSUE: begin
                if (cur_code == CODE_LOAD) begin
                    state_n   = STREAM;
                    pix_cnt_n = '0;
                    cmd_n     = cur_code;
                    datain_n  = img_data;
                end else begin
                    state_n = WAITLO;
                end
            end
            STREAM: begin
                if (pix_cnt == LAST_PIX) begin
                    state_n = WAITLO;
                end else begin
                    pix_cnt_n = pix_cnt + 7'd1;
                    cmd_n     = cur_code;
                    datain_n  = img_data;
                end
            end
            WAITLO: begin
`ifdef LCD_FEEDER_TIMEOUT_EN
                // err shows in the 256th WAITLO cycle; the wait is abandoned after it.
                to_cnt_n = to_cnt + 8'd1;
                if (to_cnt == 8'hFF) begin
                    state_n = IDLE;
                end else if (!busy) begin
                    state_n    = IDLE;
                    cmd_done_n = 1'b1;
                end else if (to_cnt == 8'hFE) begin
                    err_n = 1'b1;
                end
`else
                if (!busy) begin
                    state_n    = IDLE;
                    cmd_done_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_code  <= '0;
            pix_cnt   <= '0;
            img_rd    <= 1'b0;
            img_addr  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            datain    <= '0;
            cmd_done  <= 1'b0;
        end else begin
            state     <= state_n;
            cur_code  <= cur_code_n;
            pix_cnt   <= pix_cnt_n;
            img_rd    <= img_rd_n;
            img_addr  <= img_addr_n;
            cmd       <= cmd_n;
            cmd_valid <= cmd_valid_n;
            datain    <= datain_n;
            cmd_done  <= cmd_done_n;
        end
    end

`ifdef LCD_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            to_cnt <= to_cnt_n;
            err    <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_feeder.sv
// Testbench for lcd_feeder: random host commands, ROM and LCD controller models, queue scoreboard.
// The timeout scenario runs only when LCD_FEEDER_TIMEOUT_EN is defined.
module tb_lcd_feeder;
    localparam int PIX = 108;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] host_cmd;
    logic       host_valid, host_ready;
    logic       img_rd;
    logic [6:0] img_addr;
    logic [7:0] img_data;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy, cmd_done, err;
    logic [2:0] fsm_state;

    logic hold_busy, ctrl_busy;
    assign busy = hold_busy | ctrl_busy;

    logic [7:0] rom [PIX];
    logic [2:0] exp_q[$];
    int  checks = 0, errors = 0;
    bit  outstanding = 1'b0;
    int  pix_idx = -1, cur_pix = -1, rd_idx = 0;
    bit  rd_prev = 1'b0, err_prev = 1'b0;

    lcd_feeder #(.FIFO_DEPTH(4), .PIX_NUM(PIX)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .busy(busy),
        .cmd_done(cmd_done), .err(err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM: data for the address strobed in one cycle is presented throughout the next.
    initial begin : rom_model
        logic       rd_s;
        logic [6:0] a_s;
        img_data = 8'h00;
        forever begin
            @(negedge clk);
            rd_s = img_rd;
            a_s  = img_addr;
            @(posedge clk);
            #1;
            img_data = rd_s ? rom[a_s] : 8'($urandom);
        end
    end

    // LCD controller: busy from the cycle after cmd_valid; a load stays busy until 16 cycles after its stream.
    initial begin : ctrl_model
        int remain;
        remain    = 0;
        ctrl_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ctrl_busy = 1'b0;
                remain    = 0;
            end else if (remain > 0) begin
                remain--;
                if (remain == 0) ctrl_busy = 1'b0;
            end else if (cmd_valid) begin
                ctrl_busy = 1'b1;
                remain    = (cmd == 3'd0) ? PIX + 16 : int'($urandom_range(1, 8));
            end
        end
    end

    // Monitor: pops the expected command on every cmd_valid and checks stream, ROM bus and done ordering.
    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                outstanding = 1'b0;
                pix_idx     = -1;
                cur_pix     = -1;
                rd_idx      = 0;
                rd_prev     = 1'b0;
                err_prev    = 1'b0;
            end else begin
                if (img_rd) begin
                    if (!rd_prev) rd_idx = 0;
                    chk("img_addr", 32'(img_addr), 32'(rd_idx));
                    rd_idx++;
                end else if (rd_prev) begin
                    chk("img_rd_run_length", 32'(rd_idx), 32'(PIX));
                end
                rd_prev = img_rd;

                if (pix_idx >= 0) begin
                    chk("datain_pixel", 32'(datain), 32'(rom[pix_idx]));
                    cur_pix = pix_idx;
                    pix_idx++;
                    if (pix_idx == PIX) pix_idx = -1;
                end else begin
                    chk("datain_idle", 32'(datain), 32'(0));
                end

                if (cmd_valid) begin
                    chk("issue_before_done", 32'(outstanding), 32'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd_valid: got cmd %0d, required no issue", cmd);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_code", 32'(cmd), 32'(e));
                        if (e == 3'd0) begin
                            chk("load_rd_lead", 32'(rd_idx), 32'(2));
                            pix_idx = 0;
                        end else begin
                            chk("nonload_no_rd", 32'(img_rd), 32'(0));
                        end
                    end
                    outstanding = 1'b1;
                end else begin
                    chk("cmd_idle", 32'(cmd), 32'(0));
                end

                if (cmd_done) begin
                    chk("done_without_issue", 32'(outstanding), 32'(1));
                    outstanding = 1'b0;
                end
`ifdef LCD_FEEDER_TIMEOUT_EN
                if (err && !err_prev) outstanding = 1'b0;
                err_prev = err;
`else
                chk("err_tied_low", 32'(err), 32'(0));
`endif
            end
        end
    end

    task automatic push(input logic [2:0] c);
        int n = 0;
        host_valid = 1'b1;
        host_cmd   = c;
        while (!host_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: host_ready %0b, required 1", host_ready);
        end else if (c != 3'd7) begin
            exp_q.push_back(c);
        end
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || outstanding) begin
            errors++;
            $display("FAIL %s_drain: %0d commands pending, required 0", name, exp_q.size() + int'(outstanding));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_host_ready"}, 32'(host_ready), 32'(1));
        chk({tag, "_img_rd"},     32'(img_rd),     32'(0));
        chk({tag, "_img_addr"},   32'(img_addr),   32'(0));
        chk({tag, "_cmd"},        32'(cmd),        32'(0));
        chk({tag, "_cmd_valid"},  32'(cmd_valid),  32'(0));
        chk({tag, "_datain"},     32'(datain),     32'(0));
        chk({tag, "_cmd_done"},   32'(cmd_done),   32'(0));
        chk({tag, "_err"},        32'(err),        32'(0));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2:0] c;
        int n;
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 3'd0;
        hold_busy  = 1'b0;
        for (int i = 0; i < PIX; i++) rom[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single load with pix[n] = n.
        push(3'd0);
        wait_idle(400, "load");

        // Code 7 is accepted and dropped.
        push(3'd7);
        push(3'd4);
        wait_idle(100, "drop");

        // Fill the FIFO while the controller is busy, then drain in order.
        hold_busy = 1'b1;
        push(3'd1);
        push(3'd3);
        push(3'd3);
        push(3'd2);
        chk("host_ready_full", 32'(host_ready), 32'(0));
        host_valid = 1'b1;
        host_cmd   = 3'd6;
        repeat (3) begin
            @(negedge clk);
            chk("host_ready_held_low", 32'(host_ready), 32'(0));
        end
        host_valid = 1'b0;
        hold_busy  = 1'b0;
        wait_idle(200, "order");

        // Random command mix with fresh ROM contents.
        for (int i = 0; i < PIX; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(0, 7));
            if (c == 3'd0 && $urandom_range(0, 3) != 0) c = 3'd5;
            push(c);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle(4000, "random");

`ifdef LCD_FEEDER_TIMEOUT_EN
        push(3'd5);
        n = 0;
        while (!outstanding && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        hold_busy = 1'b1;
        push(3'd2);
        n = 1;
        while (!err && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("timeout_err", 32'(err), 32'(1));
        chk("timeout_cycle", 32'(n), 32'(256));
        hold_busy = 1'b0;
        wait_idle(100, "after_timeout");
        chk("err_sticky", 32'(err), 32'(1));
`endif

        // Reset in the middle of a stream.
        push(3'd0);
        n = 0;
        while (cur_pix != 50 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_pixel_50", 32'(cur_pix), 32'(50));
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs("midload_reset");
        reset = 1'b0;
        repeat (150) begin
            @(negedge clk);
            #1;
            chk("post_reset_img_rd",    32'(img_rd),    32'(0));
            chk("post_reset_cmd_valid", 32'(cmd_valid), 32'(0));
            chk("post_reset_cmd_done",  32'(cmd_done),  32'(0));
        end
        push(3'd3);
        wait_idle(100, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
